// File: rtl/addseq_pkg.sv
// Shared constants and FSM state type for the nibble-serial adder sequencer.
package addseq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addseq_state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_adder_ctrl.
// The sub wire exists only when ADDSEQ_SUB_EN is defined.
interface nibble_serial_adder_ctrl_if
  import addseq_pkg::*;
#(
  parameter int WIDTH = 16
);
  // Valid/ready: a transfer happens on a rising clk edge where both are high;
  // valid may not depend on ready, and payload is only sampled on a transfer.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef ADDSEQ_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;
  addseq_state_t    dbg_state;

  modport master (
    output in_valid, a, b, c_in,
`ifdef ADDSEQ_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, c_out, busy, dbg_state
  );

  modport slave (
    input  in_valid, a, b, c_in,
`ifdef ADDSEQ_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, c_out, busy, dbg_state
  );

endinterface

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry slice built from per-bit full adders.
module nibble_add4
  import addseq_pkg::*;
(
  input  logic [NIB_W-1:0] i_a4,
  input  logic [NIB_W-1:0] i_b4,
  input  logic             i_ci,
  output logic [NIB_W-1:0] o_s4,
  output logic             o_co
);

  logic [NIB_W:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign o_s4[i]  = i_a4[i] ^ i_b4[i] ^ w_c[i];
    assign w_c[i+1] = (i_a4[i] & i_b4[i]) | (w_c[i] & (i_a4[i] ^ i_b4[i]));
  end

  assign o_co = w_c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add (optionally subtract with ADDSEQ_SUB_EN) done one nibble per
// cycle through a single nibble_add4 slice, LSB nibble first.
module nibble_serial_adder_ctrl
  import addseq_pkg::*;
#(
  parameter int WIDTH = 16
)(
  input  logic                       clk,
  input  logic                       rst_n,
  nibble_serial_adder_ctrl_if.slave  bus
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  addseq_state_t    r_state, w_state_next;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_sum_sh, r_sum;
  logic             r_carry, r_c_out;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept, w_in_ready, w_last, w_co, w_carry_init;
  logic [NIB_W-1:0] w_b4, w_s4;
  logic [WIDTH-1:0] w_sum_next;

`ifdef ADDSEQ_SUB_EN
  logic r_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_sub <= 1'b0;
    else if (w_accept) r_sub <= bus.sub;
  end

  // a - b - c_in == a + ~b + ~c_in (two's complement, borrow in inverted)
  assign w_b4         = r_b_sh[NIB_W-1:0] ^ {NIB_W{r_sub}};
  assign w_carry_init = bus.c_in ^ bus.sub;
`else
  assign w_b4         = r_b_sh[NIB_W-1:0];
  assign w_carry_init = bus.c_in;
`endif

  nibble_add4 u_slice (
    .i_a4 (r_a_sh[NIB_W-1:0]),
    .i_b4 (w_b4),
    .i_ci (r_carry),
    .o_s4 (w_s4),
    .o_co (w_co)
  );

  assign w_last     = (r_cnt == CNT_LAST);
  assign w_sum_next = (r_sum_sh >> NIB_W) | (WIDTH'(w_s4) << (WIDTH - NIB_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = rst_n;
        w_accept   = bus.in_valid & w_in_ready;
        if (w_accept) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        // Result handoff and next accept share one edge: no idle bubble.
        w_in_ready = bus.out_ready;
        w_accept   = bus.in_valid & bus.out_ready;
        if (bus.out_ready) w_state_next = bus.in_valid ? RUN : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_c_out  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_carry <= w_carry_init;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a_sh   <= r_a_sh >> NIB_W;
      r_b_sh   <= r_b_sh >> NIB_W;
      r_sum_sh <= w_sum_next;
      r_carry  <= w_co;
      if (w_last) begin
        r_cnt   <= '0;
        r_sum   <= w_sum_next;
        r_c_out <= w_co;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == RUN);
  assign bus.sum       = r_sum;
  assign bus.c_out     = r_c_out;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16); the subtract cases
// run only when ADDSEQ_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;
  import addseq_pkg::*;

  localparam int WIDTH = 16;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus();

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // scoreboard: {c_out, sum}
  logic [WIDTH:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ci, input logic sub);
    bus.a    = a;
    bus.b    = b;
    bus.c_in = ci;
`ifdef ADDSEQ_SUB_EN
    bus.sub  = sub;
`else
    if (sub) $display("note: sub requested without ADDSEQ_SUB_EN");
`endif
  endtask

  task automatic accept(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic sub, input logic [WIDTH:0] exp);
    int t;
    drive(a, b, ci, sub);
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      tick();
      t++;
    end
    check({tag, "_in_ready_wait"}, 32'(t < 50), 32'd1);
    exp_q.push_back(exp);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    logic [WIDTH:0] e;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_sum"}, 32'(bus.sum), 32'(e[WIDTH-1:0]));
    check({tag, "_c_out"}, 32'(bus.c_out), 32'(e[WIDTH]));
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic sub,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_co);
    accept(tag, a, b, ci, sub, {exp_co, exp_sum});
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_result(tag, 4);
    tick();
    check({tag, "_idle_after"}, 32'(bus.dbg_state), 32'(IDLE));
    check({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  logic [WIDTH-1:0] b2b_a   [3] = '{16'h1111, 16'hFFFE, 16'h00FF};
  logic [WIDTH-1:0] b2b_b   [3] = '{16'h2222, 16'h0001, 16'h0F01};
  logic             b2b_ci  [3] = '{1'b0, 1'b1, 1'b0};
  logic [WIDTH:0]   b2b_exp [3] = '{17'h03333, 17'h10000, 17'h01000};

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t_prev;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0);

    // reset state
    repeat (3) tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_c_out", 32'(bus.c_out), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));

    // basic and carry-ripple adds
    run_op("basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    run_op("ripple1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("ripple2", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0);
    run_op("msb_co",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);

    // backpressure in DONE
    bus.out_ready = 1'b0;
    accept("bp", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 17'h10000);
    wait_result("bp", 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_sum", 32'(bus.sum), 32'h0000);
      check("bp_hold_c_out", 32'(bus.c_out), 32'd1);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_state", 32'(bus.dbg_state), 32'(IDLE));

    // back-to-back with in_valid held
    drive(b2b_a[0], b2b_b[0], b2b_ci[0], 1'b0);
    bus.in_valid = 1'b1;
    exp_q.push_back(b2b_exp[0]);
    tick();
    t_prev = 0;
    for (int i = 1; i < 3; i++) begin
      drive(b2b_a[i], b2b_b[i], b2b_ci[i], 1'b0);
      exp_q.push_back(b2b_exp[i]);
      wait_result("b2b", 4);
      if (i > 1) check("b2b_period", cyc - t_prev, 32'd5);
      t_prev = cyc;
      check("b2b_in_ready_done", 32'(bus.in_ready), 32'd1);
      tick();
      check("b2b_reaccept_busy", 32'(bus.busy), 32'd1);
    end
    bus.in_valid = 1'b0;
    wait_result("b2b_last", 4);
    check("b2b_period_last", cyc - t_prev, 32'd5);
    tick();
    check("b2b_idle", 32'(bus.dbg_state), 32'(IDLE));

    // reset in the middle of RUN
    accept("mid_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 17'h02345);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);

`ifdef ADDSEQ_SUB_EN
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    run_op("add_after_sub", 16'h0007, 16'h0005, 1'b0, 1'b0, 16'h000C, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
